sha1_slot_sched: RTL and testbench

Parametrised chunk scheduler for an interleaved, pipelined SHA-1 compression core. It accepts 512-bit chunks under a valid/ready handshake and assigns them round-robin to `SLOTS` message contexts. For each context it tracks first/last/open state and the in-flight count, forwards chunks to the core, and emits a tagged hash when a message's final chunk completes. It sits between the host-side message packer and the SHA-1 chunk core, generalising the fixed 4-message controller to N contexts with backpressure and protocol-error reporting.

---
 rtl/sha1_slot_sched.sv | 149 ++++++++++++++
 tb/tb_sha1_slot_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_slot_sched.sv
// sha1_slot_sched
//
// Round-robin chunk scheduler for an interleaved, pipelined SHA-1 chunk core.
// Accepted 512-bit chunks are assigned to SLOTS message contexts in strict
// rotation. Each context tracks whether a message is open and whether its
// in-flight chunk is the last one. Chunks are forwarded to the core one cycle
// after acceptance. A tagged digest is emitted one cycle after the core
// completes a message's final chunk.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   start_i / ready_o          chunk valid / ready handshake
//   msg_i, is_first_i,
//   is_last_i                  chunk data and message-boundary flags
//   core_start_o, core_msg_o,
//   core_first_o, core_slot_o  registered issue to the core (IV load on first)
//   core_done_i, core_slot_i,
//   core_hash_i                completion from the core with chaining value
//   hash_o, hash_valid_o,
//   hash_slot_o                final digest strobe and its slot tag
//   busy_o                     chunks in flight, open message or digest pending
//   err_o                      sticky protocol error, cleared only by reset

module sha1_slot_sched #(
  parameter int unsigned SLOTS  = 4,
  parameter int unsigned SLOT_W = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  output logic              ready_o,
  input  logic [511:0]      msg_i,
  input  logic              is_first_i,
  input  logic              is_last_i,
  output logic              core_start_o,
  output logic [511:0]      core_msg_o,
  output logic              core_first_o,
  output logic [SLOT_W-1:0] core_slot_o,
  input  logic              core_done_i,
  input  logic [SLOT_W-1:0] core_slot_i,
  input  logic [159:0]      core_hash_i,
  output logic [159:0]      hash_o,
  output logic              hash_valid_o,
  output logic [SLOT_W-1:0] hash_slot_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [SLOT_W:0]   SlotsCnt = (SLOT_W + 1)'(SLOTS);
  localparam logic [SLOT_W:0]   CntOne   = (SLOT_W + 1)'(1);
  localparam logic [SLOT_W-1:0] SlotOne  = SLOT_W'(1);

  logic [SLOT_W-1:0] slot_in_q, slot_in_d;
  logic [SLOT_W-1:0] slot_out_q, slot_out_d;
  logic [SLOT_W:0]   in_flight_q, in_flight_d;
  logic [SLOTS-1:0]  open_q, open_d;
  logic [SLOTS-1:0]  last_q, last_d;

  logic accept;
  logic done_ok;
  logic hash_hit;
  logic first_err;
  logic spurious_err;
  logic order_err;

  // A done with nothing in flight is dropped entirely.
  assign done_ok = core_done_i && (in_flight_q != '0);

  // A same-cycle done frees a position, so a full pipe can still accept.
  assign ready_o = (in_flight_q < SlotsCnt) || done_ok;
  assign accept  = start_i && ready_o;

  assign hash_hit = done_ok && last_q[core_slot_i];

  // First chunk into an open slot, or a continuation into a closed one.
  assign first_err    = accept && (is_first_i == open_q[slot_in_q]);
  assign spurious_err = core_done_i && (in_flight_q == '0);
  assign order_err    = done_ok && (core_slot_i != slot_out_q);

  assign busy_o = (in_flight_q != '0) || (|open_q) || hash_valid_o;

  always_comb begin
    slot_in_d   = slot_in_q;
    slot_out_d  = slot_out_q;
    in_flight_d = in_flight_q;
    open_d      = open_q;
    last_d      = last_q;

    case ({accept, done_ok})
      2'b10:   in_flight_d = in_flight_q + CntOne;
      2'b01:   in_flight_d = in_flight_q - CntOne;
      default: in_flight_d = in_flight_q;
    endcase

    if (done_ok) begin
      slot_out_d          = slot_out_q + SlotOne;
      last_d[core_slot_i] = 1'b0;
    end

    // Accept is applied after done so a new last chunk into the slot that
    // just completed keeps its flag.
    if (accept) begin
      slot_in_d = slot_in_q + SlotOne;
      // Any non-last chunk leaves the context open; a stray continuation
      // into a closed slot is treated as a fresh first chunk.
      open_d[slot_in_q] = !is_last_i;
      if (is_last_i) begin
        last_d[slot_in_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_in_q    <= '0;
      slot_out_q   <= '0;
      in_flight_q  <= '0;
      open_q       <= '0;
      last_q       <= '0;
      core_start_o <= 1'b0;
      core_msg_o   <= '0;
      core_first_o <= 1'b0;
      core_slot_o  <= '0;
      hash_o       <= '0;
      hash_valid_o <= 1'b0;
      hash_slot_o  <= '0;
      err_o        <= 1'b0;
    end else begin
      slot_in_q    <= slot_in_d;
      slot_out_q   <= slot_out_d;
      in_flight_q  <= in_flight_d;
      open_q       <= open_d;
      last_q       <= last_d;
      core_start_o <= accept;
      if (accept) begin
        core_msg_o   <= msg_i;
        core_first_o <= is_first_i || !open_q[slot_in_q];
        core_slot_o  <= slot_in_q;
      end
      hash_valid_o <= hash_hit;
      if (hash_hit) begin
        hash_o      <= core_hash_i;
        hash_slot_o <= core_slot_i;
      end
      err_o <= err_o || first_err || spurious_err || order_err;
    end
  end

endmodule

// File: tb/tb_sha1_slot_sched.sv
module tb_sha1_slot_sched;

  localparam int unsigned SLOTS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main DUT (4 slots)
  logic         start, is_first, is_last, done;
  logic [511:0] msg;
  logic [1:0]   done_slot;
  logic [159:0] done_hash;
  logic         ready, core_start, core_first, hash_valid, busy, err;
  logic [511:0] core_msg;
  logic [1:0]   core_slot, hash_slot;
  logic [159:0] hash;

  // Second DUT (2 slots) for backpressure
  logic         start2, first2, last2, done2;
  logic [0:0]   done_slot2;
  logic         ready2, core_start2, core_first2, hash_valid2, busy2, err2;
  logic [511:0] core_msg2;
  logic [0:0]   core_slot2, hash_slot2;
  logic [159:0] hash2;

  sha1_slot_sched #(.SLOTS(4)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .ready_o      (ready),
    .msg_i        (msg),
    .is_first_i   (is_first),
    .is_last_i    (is_last),
    .core_start_o (core_start),
    .core_msg_o   (core_msg),
    .core_first_o (core_first),
    .core_slot_o  (core_slot),
    .core_done_i  (done),
    .core_slot_i  (done_slot),
    .core_hash_i  (done_hash),
    .hash_o       (hash),
    .hash_valid_o (hash_valid),
    .hash_slot_o  (hash_slot),
    .busy_o       (busy),
    .err_o        (err)
  );

  sha1_slot_sched #(.SLOTS(2)) u_dut2 (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start2),
    .ready_o      (ready2),
    .msg_i        (msg),
    .is_first_i   (first2),
    .is_last_i    (last2),
    .core_start_o (core_start2),
    .core_msg_o   (core_msg2),
    .core_first_o (core_first2),
    .core_slot_o  (core_slot2),
    .core_done_i  (done2),
    .core_slot_i  (done_slot2),
    .core_hash_i  (done_hash),
    .hash_o       (hash2),
    .hash_valid_o (hash_valid2),
    .hash_slot_o  (hash_slot2),
    .busy_o       (busy2),
    .err_o        (err2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of in-flight chunks plus per-slot open flags.
  int           q_slot[$];
  bit           q_last[$];
  bit           open_m[SLOTS];
  int           sin_m;
  bit           err_m;
  bit           e_cs, e_cf, e_hv, e_busy;
  int           e_cslot, e_hslot;
  logic [511:0] e_cmsg;
  logic [159:0] e_hash;
  int           n_first_obs, n_hv_obs;

  typedef struct {
    bit         st, fi, la, dn;
    logic [1:0] ds;
    bit         rdy, cs;
    logic [1:0] cslot;
    bit         hv;
    logic [1:0] hslot;
    bit         busy;
  } vec_t;

  vec_t tbl[11];
  vec_t cur_v;
  bit   use_v = 1'b0;

  task automatic model_clear();
    q_slot.delete();
    q_last.delete();
    for (int i = 0; i < SLOTS; i++) open_m[i] = 1'b0;
    sin_m  = 0;
    err_m  = 1'b0;
    e_cs   = 1'b0;
    e_cf   = 1'b0;
    e_hv   = 1'b0;
    e_busy = 1'b0;
    e_cslot = 0;
    e_hslot = 0;
    e_cmsg = '0;
    e_hash = '0;
  endtask

  task automatic check_outputs();
    chk("core_start_o", 512'(core_start), 512'(e_cs));
    if (e_cs) begin
      chk("core_slot_o", 512'(core_slot), 512'(e_cslot));
      chk("core_first_o", 512'(core_first), 512'(e_cf));
      chk("core_msg_o", core_msg, e_cmsg);
    end
    chk("hash_valid_o", 512'(hash_valid), 512'(e_hv));
    if (e_hv) begin
      chk("hash_slot_o", 512'(hash_slot), 512'(e_hslot));
      chk("hash_o", 512'(hash), 512'(e_hash));
    end
    chk("busy_o", 512'(busy), 512'(e_busy));
    chk("err_o", 512'(err), 512'(err_m));
    if (core_start && core_first) n_first_obs++;
    if (hash_valid) n_hv_obs++;
  endtask

  task automatic check_vec();
    chk("vec ready_o", 512'(ready), 512'(cur_v.rdy));
    chk("vec core_start_o", 512'(core_start), 512'(cur_v.cs));
    if (cur_v.cs) chk("vec core_slot_o", 512'(core_slot), 512'(cur_v.cslot));
    chk("vec hash_valid_o", 512'(hash_valid), 512'(cur_v.hv));
    if (cur_v.hv) chk("vec hash_slot_o", 512'(hash_slot), 512'(cur_v.hslot));
    chk("vec busy_o", 512'(busy), 512'(cur_v.busy));
  endtask

  // Evaluates the current cycle's inputs and sets expectations for the next.
  task automatic model_step();
    int n;
    int s;
    bit rdy, acc, hv, any_open;
    n   = q_slot.size();
    rdy = (n < SLOTS) || (done && n > 0);
    chk("ready_o", 512'(ready), 512'(rdy));
    acc = start && rdy;
    hv  = 1'b0;
    if (done) begin
      if (n == 0) begin
        err_m = 1'b1;
      end else begin
        if (int'(done_slot) != q_slot[0]) err_m = 1'b1;
        hv = q_last[0];
        void'(q_slot.pop_front());
        void'(q_last.pop_front());
      end
    end
    e_hv = hv;
    if (hv) begin
      e_hslot = int'(done_slot);
      e_hash  = done_hash;
    end
    e_cs = acc;
    if (acc) begin
      s       = sin_m;
      e_cslot = s;
      e_cmsg  = msg;
      e_cf    = is_first || !open_m[s];
      if (is_first && open_m[s]) err_m = 1'b1;
      if (!is_first && !open_m[s]) err_m = 1'b1;
      if (is_last) open_m[s] = 1'b0;
      else open_m[s] = 1'b1;
      q_slot.push_back(s);
      q_last.push_back(is_last);
      sin_m = (s + 1) % SLOTS;
    end
    any_open = 1'b0;
    for (int i = 0; i < SLOTS; i++) any_open |= open_m[i];
    e_busy = (q_slot.size() != 0) || any_open || hv;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic cyc();
    @(negedge clk);
    check_outputs();
    if (use_v) check_vec();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input bit fi, input bit la, input bit dn,
                       input logic [1:0] ds);
    start     = st;
    is_first  = fi;
    is_last   = la;
    done      = dn;
    done_slot = ds;
    for (int i = 0; i < 16; i++) msg[i*32 +: 32] = $urandom;
    for (int i = 0; i < 5; i++) done_hash[i*32 +: 32] = $urandom;
    cyc();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  // Asserts reset mid-cycle, checks outputs cleared at once, releases it.
  task automatic async_reset();
    start  = 1'b0;
    done   = 1'b0;
    start2 = 1'b0;
    done2  = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst core_start_o", 512'(core_start), 512'(0));
    chk("rst core_msg_o", core_msg, 512'(0));
    chk("rst core_first_o", 512'(core_first), 512'(0));
    chk("rst core_slot_o", 512'(core_slot), 512'(0));
    chk("rst hash_o", 512'(hash), 512'(0));
    chk("rst hash_valid_o", 512'(hash_valid), 512'(0));
    chk("rst hash_slot_o", 512'(hash_slot), 512'(0));
    chk("rst busy_o", 512'(busy), 512'(0));
    chk("rst err_o", 512'(err), 512'(0));
    chk("rst ready_o", 512'(ready), 512'(1));
    chk("rst ready2", 512'(ready2), 512'(1));
    chk("rst busy2", 512'(busy2), 512'(0));
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit st, fi, la, dn;
    logic [1:0] ds;

    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};

    reset = 1'b1;
    start = 1'b0; is_first = 1'b0; is_last = 1'b0; done = 1'b0; done_slot = '0;
    msg = '0; done_hash = '0;
    start2 = 1'b0; first2 = 1'b0; last2 = 1'b0; done2 = 1'b0; done_slot2 = '0;
    model_clear();
    @(posedge clk);
    #1;
    async_reset();

    // 1: four single-chunk messages, dones in order
    use_v = 1'b1;
    for (int k = 0; k < 11; k++) begin
      cur_v = tbl[k];
      drive(tbl[k].st, tbl[k].fi, tbl[k].la, tbl[k].dn, tbl[k].ds);
    end
    use_v = 1'b0;

    // 2: three-chunk message per slot, interleaved
    n_first_obs = 0;
    n_hv_obs    = 0;
    for (int k = 0; k < 17; k++) begin
      drive(k < 12, k < 4, k >= 8, (k >= 2) && (k < 14), 2'((k - 2) % 4));
    end
    chk("t2 first issues", 512'(n_first_obs), 512'(4));
    chk("t2 digests", 512'(n_hv_obs), 512'(4));

    // 3: backpressure on the 2-slot instance
    start2 = 1'b1; first2 = 1'b1; last2 = 1'b1;
    #1 chk("t3 ready first", 512'(ready2), 512'(1));
    idle(1);
    #1 chk("t3 ready second", 512'(ready2), 512'(1));
    chk("t3 issue0 slot", 512'(core_slot2), 512'(0));
    idle(1);
    #1 chk("t3 ready full", 512'(ready2), 512'(0));
    chk("t3 issue1 start", 512'(core_start2), 512'(1));
    chk("t3 issue1 slot", 512'(core_slot2), 512'(1));
    idle(1);
    #1 chk("t3 ready held", 512'(ready2), 512'(0));
    chk("t3 no issue while held", 512'(core_start2), 512'(0));
    idle(1);
    done2 = 1'b1; done_slot2 = 1'b0;
    #1 chk("t3 ready with done", 512'(ready2), 512'(1));
    idle(1);
    start2 = 1'b0; done2 = 1'b0;
    #1 chk("t3 pending issued", 512'(core_start2), 512'(1));
    chk("t3 pending slot", 512'(core_slot2), 512'(0));
    chk("t3 pending first", 512'(core_first2), 512'(1));
    chk("t3 digest valid", 512'(hash_valid2), 512'(1));
    chk("t3 digest slot", 512'(hash_slot2), 512'(0));
    chk("t3 ready after", 512'(ready2), 512'(0));
    chk("t3 err", 512'(err2), 512'(0));
    idle(1);

    // 4: accept and done together at full occupancy
    async_reset();
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
    chk("t4 issue start", 512'(core_start), 512'(1));
    chk("t4 issue slot", 512'(core_slot), 512'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
    chk("t4 next slot", 512'(core_slot), 512'(1));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    idle(2);

    // 5a: first chunk into an open slot
    async_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
    chk("t5a err", 512'(err), 512'(1));
    chk("t5a restart first", 512'(core_first), 512'(1));
    chk("t5a restart slot", 512'(core_slot), 512'(0));
    for (int k = 1; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 1'b1, 2'(k % 4));
    idle(2);
    chk("t5a err sticky", 512'(err), 512'(1));

    // 5b: spurious done
    async_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    chk("t5b err", 512'(err), 512'(1));
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("t5b slot unchanged", 512'(core_slot), 512'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    idle(2);

    // 5c: completion slot out of order
    async_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    chk("t5c err clean", 512'(err), 512'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    chk("t5c err", 512'(err), 512'(1));
    idle(3);
    chk("t5c err sticky", 512'(err), 512'(1));

    // 6: reset with three chunks in flight
    async_reset();
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    async_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    chk("t6 no late digest", 512'(hash_valid), 512'(0));
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("t6 slot0 first", 512'(core_slot), 512'(0));
    chk("t6 issued", 512'(core_start), 512'(1));
    idle(1);

    // Randomized legal traffic against the model
    async_reset();
    for (int it = 0; it < 3000; it++) begin
      st = ($urandom % 10) < 6;
      fi = !open_m[sin_m];
      la = ($urandom % 3) == 0;
      dn = (q_slot.size() > 0) && ($urandom % 2 == 1);
      if (dn) ds = 2'(q_slot[0]);
      else ds = 2'($urandom);
      drive(st, fi, la, dn, ds);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
